// File: rtl/hacd_pkg.sv
// Shared HAWK control-unit package: table-read packet types, the 8-byte byteswap
// helper and an entry-size-generic slot extractor.
package hacd_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int LINE_W      = 512;
    localparam int MAX_ENTRY_W = 128;

    typedef struct packed {
        logic [23:0] idx;
        logic [63:0] base;
        logic        valid;
    } tbl_rd_reqpkt_t;

    typedef struct packed {
        logic [MAX_ENTRY_W-1:0] entry;
        logic                   err;
        logic                   valid;
    } tbl_rd_rsppkt_t;

    function automatic logic [LINE_W-1:0] bswap64_line(input logic [LINE_W-1:0] line);
        logic [LINE_W-1:0] res;
        res = '0;
        for (int w = 0; w < LINE_W / 64; w++) begin
            for (int b = 0; b < 8; b++) begin
                res[w*64 + b*8 +: 8] = line[w*64 + (7-b)*8 +: 8];
            end
        end
        return res;
    endfunction

    // Result is right-aligned; bits above entry_bytes*8 are zero.
    function automatic logic [MAX_ENTRY_W-1:0] extract_slot(input logic [LINE_W-1:0] line,
                                                            input int unsigned entry_bytes,
                                                            input logic [5:0] slot);
        logic [LINE_W-1:0]      shifted;
        logic [MAX_ENTRY_W-1:0] res;
        shifted = line >> (32'(slot) * entry_bytes * 32'd8);
        res     = shifted[MAX_ENTRY_W-1:0];
        if (entry_bytes == 8) begin
            res[MAX_ENTRY_W-1:64] = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/hawk_line_buf.sv
// Single-cacheline buffer holding the most recently fetched table line and its tag.
module hawk_line_buf #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inval,
    output logic              valid,
    output logic [ADDR_W-1:0] tag,
    output logic [DATA_W-1:0] data
);

    // An invalidate arriving together with a fill wins: the fetched copy may be stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (inval) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            data  <= fill_data;
        end
    end

endmodule

// File: rtl/hawk_tbl_entry_rdr.sv
// Table-entry reader: fetches the cacheline holding an ATT/list entry over a single-beat
// AXI read, byteswaps it and returns the addressed entry; one-line buffer for reuse.
module hawk_tbl_entry_rdr
    import hacd_pkg::*;
#(
    parameter int ENTRY_BYTES = 8,
    parameter int IDX_W       = 24,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 512,
    parameter int LEN_W       = 8,
    parameter int BYTESWAP    = 1,
    parameter int LINEBUF_EN  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [IDX_W-1:0]         req_idx_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic                     inval_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [ENTRY_BYTES*8-1:0] rsp_entry_o,
    output logic                     rsp_err_o,
    output logic [ADDR_W-1:0]        araddr_o,
    output logic [LEN_W-1:0]         arlen_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [DATA_W-1:0]        rdata_i,
    input  logic [1:0]               rresp_i,
    input  logic                     rvalid_i,
    input  logic                     rlast_i,
    output logic                     rready_o
);

    localparam int EW     = ENTRY_BYTES * 8;
    localparam int SLOT_W = $clog2(LINE_BYTES / ENTRY_BYTES);

    typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;

    state_t              state_q, state_d;
    logic                ready_en_q;
    logic [ADDR_W-1:0]   line_addr_q;
    logic [SLOT_W-1:0]   slot_q;
    logic                got_beat_q;
    logic [DATA_W-1:0]   cap_q;
    logic [1:0]          resp_q;
    logic [EW-1:0]       entry_q;
    logic                err_q;

    logic [ADDR_W-1:0]      offset, line_addr_d;
    logic [SLOT_W-1:0]      slot_d;
    logic [DATA_W-1:0]      line_in, beat_line;
    logic [1:0]             beat_resp;
    logic                   beat, last_beat, beat_err, accept, hit;
    logic [MAX_ENTRY_W-1:0] hit_ext, beat_ext;
    logic                   buf_valid;
    logic [ADDR_W-1:0]      buf_tag;
    logic [DATA_W-1:0]      buf_data;

    assign offset      = ADDR_W'(req_idx_i) * ADDR_W'(ENTRY_BYTES);
    assign line_addr_d = base_addr_i + (offset & ~ADDR_W'(63));
    assign slot_d      = req_idx_i[SLOT_W-1:0];

    assign line_in   = (BYTESWAP != 0) ? bswap64_line(rdata_i) : rdata_i;
    assign beat      = (state_q == R) && rvalid_i;
    assign last_beat = beat && rlast_i;
    // Only the first R beat carries the line; a single-beat burst is used straight off the bus.
    assign beat_line = got_beat_q ? cap_q : line_in;
    assign beat_resp = got_beat_q ? resp_q : rresp_i;
    assign beat_err  = (beat_resp != 2'b00);

    assign accept = req_valid_i && req_ready_o;
    assign hit    = (LINEBUF_EN != 0) && buf_valid && (buf_tag == line_addr_d) && !inval_i;

    assign hit_ext  = extract_slot(buf_data, ENTRY_BYTES, 6'(slot_d));
    assign beat_ext = extract_slot(beat_line, ENTRY_BYTES, 6'(slot_q));

    hawk_line_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_line_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .fill      (last_beat && !beat_err && (LINEBUF_EN != 0)),
        .fill_tag  (line_addr_q),
        .fill_data (beat_line),
        .inval     (inval_i || (last_beat && beat_err)),
        .valid     (buf_valid),
        .tag       (buf_tag),
        .data      (buf_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = ready_en_q;
                if (req_valid_i && ready_en_q) begin
                    state_d = hit ? RSP : AR;
                end
            end
            AR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_d = R;
            end
            R: begin
                rready_o = 1'b1;
                if (rvalid_i && rlast_i) state_d = RSP;
            end
            RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_en_q keeps req_ready_o low until the first clock after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_en_q  <= 1'b0;
            line_addr_q <= '0;
            slot_q      <= '0;
            got_beat_q  <= 1'b0;
            cap_q       <= '0;
            resp_q      <= 2'b00;
            entry_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                line_addr_q <= line_addr_d;
                slot_q      <= slot_d;
                got_beat_q  <= 1'b0;
                if (hit) begin
                    entry_q <= hit_ext[EW-1:0];
                    err_q   <= 1'b0;
                end
            end
            if (beat && !got_beat_q) begin
                cap_q      <= line_in;
                resp_q     <= rresp_i;
                got_beat_q <= 1'b1;
            end
            if (last_beat) begin
                err_q   <= beat_err;
                entry_q <= beat_err ? '0 : beat_ext[EW-1:0];
            end
        end
    end

    assign araddr_o    = line_addr_q;
    assign arlen_o     = '0;
    assign rsp_entry_o = entry_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_hawk_tbl_entry_rdr.sv
// Bench for hawk_tbl_entry_rdr: three configurations (8B swapped, 16B swapped, 16B raw)
// driven against a byte-level reference model and a behavioural AXI memory.
module tb_hawk_tbl_entry_rdr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [3], req_ready [3], inval [3];
    logic        rsp_valid [3], rsp_ready [3], rsp_err [3];
    logic [23:0] req_idx [3];
    logic [63:0] base_addr [3];
    logic [63:0] araddr [3];
    logic [7:0]  arlen [3];
    logic        arvalid [3], arready [3];
    logic [511:0] rdata [3];
    logic [1:0]  rresp [3];
    logic        rvalid [3], rlast [3], rready [3];
    logic [63:0]  entry0;
    logic [127:0] entry1, entry2;

    int  eb_of   [3] = '{8, 16, 16};
    bit  swap_of [3] = '{1'b1, 1'b1, 1'b0};

    int          ar_delay [3], r_beats [3], r_gap [3], ar_count [3];
    int unsigned mem_gen [3];
    logic [1:0]  r_err [3];
    bit          inval_on_last [3];
    logic [63:0] last_ar_addr [3];
    logic [7:0]  last_arlen [3];

    bit           mb_valid [3];
    logic [63:0]  mb_tag [3];
    logic [511:0] mb_line [3];

    int vectors = 0;
    int miscompares = 0;

    hawk_tbl_entry_rdr #(.ENTRY_BYTES(8), .BYTESWAP(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_idx_i(req_idx[0]), .base_addr_i(base_addr[0]), .inval_i(inval[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_entry_o(entry0),
        .rsp_err_o(rsp_err[0]), .araddr_o(araddr[0]), .arlen_o(arlen[0]), .arvalid_o(arvalid[0]),
        .arready_i(arready[0]), .rdata_i(rdata[0]), .rresp_i(rresp[0]), .rvalid_i(rvalid[0]),
        .rlast_i(rlast[0]), .rready_o(rready[0]));

    hawk_tbl_entry_rdr #(.ENTRY_BYTES(16), .BYTESWAP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_idx_i(req_idx[1]), .base_addr_i(base_addr[1]), .inval_i(inval[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_entry_o(entry1),
        .rsp_err_o(rsp_err[1]), .araddr_o(araddr[1]), .arlen_o(arlen[1]), .arvalid_o(arvalid[1]),
        .arready_i(arready[1]), .rdata_i(rdata[1]), .rresp_i(rresp[1]), .rvalid_i(rvalid[1]),
        .rlast_i(rlast[1]), .rready_o(rready[1]));

    hawk_tbl_entry_rdr #(.ENTRY_BYTES(16), .BYTESWAP(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
        .req_idx_i(req_idx[2]), .base_addr_i(base_addr[2]), .inval_i(inval[2]),
        .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_entry_o(entry2),
        .rsp_err_o(rsp_err[2]), .araddr_o(araddr[2]), .arlen_o(arlen[2]), .arvalid_o(arvalid[2]),
        .arready_i(arready[2]), .rdata_i(rdata[2]), .rresp_i(rresp[2]), .rvalid_i(rvalid[2]),
        .rlast_i(rlast[2]), .rready_o(rready[2]));

    function automatic logic [127:0] entry_of(input int g);
        if (g == 0) return {64'b0, entry0};
        if (g == 1) return entry1;
        return entry2;
    endfunction

    // Backing memory contents: a deterministic pattern of address, instance and table generation.
    function automatic logic [511:0] mem_line(input int g, input logic [63:0] addr, input int unsigned gen);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) begin
            l[w*32 +: 32] = (addr[31:0] * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^
                            (gen * 32'hC2B2AE35) ^ (32'(g) << 24);
        end
        return l;
    endfunction

    function automatic logic [63:0] ref_line_addr(input logic [63:0] base, input logic [23:0] idx, input int eb);
        return base + ((64'(idx) * 64'(eb)) / 64) * 64;
    endfunction

    // Entry byte j is line byte slot*eb+j, read through the per-8-byte byte reversal.
    function automatic logic [127:0] ref_entry(input logic [511:0] line, input int eb, input bit swap,
                                               input logic [23:0] idx);
        logic [127:0] e;
        int slot;
        int k;
        int src;
        e    = '0;
        slot = int'(idx) % (64 / eb);
        for (int j = 0; j < eb; j++) begin
            k   = slot * eb + j;
            src = swap ? (k / 8) * 8 + 7 - (k % 8) : k;
            e[j*8 +: 8] = line[src*8 +: 8];
        end
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_mem
        initial begin
            logic [63:0] a;
            int gap;
            arready[g] = 1'b0;
            rvalid[g]  = 1'b0;
            rlast[g]   = 1'b0;
            rdata[g]   = '0;
            rresp[g]   = 2'b00;
            forever begin
                @(negedge clk);
                if (arvalid[g] === 1'b1) begin
                    repeat (ar_delay[g]) @(negedge clk);
                    arready[g]      = 1'b1;
                    a               = araddr[g];
                    last_ar_addr[g] = araddr[g];
                    last_arlen[g]   = arlen[g];
                    ar_count[g]++;
                    @(negedge clk);
                    arready[g] = 1'b0;
                    gap = (r_gap[g] < 0) ? int'($urandom_range(0, 2)) : r_gap[g];
                    repeat (gap) @(negedge clk);
                    for (int b = 0; b < r_beats[g]; b++) begin
                        rvalid[g] = 1'b1;
                        rlast[g]  = (b == r_beats[g] - 1);
                        if (b == 0) begin
                            rdata[g] = mem_line(g, a, mem_gen[g]);
                            rresp[g] = r_err[g];
                        end else begin
                            rdata[g] = {16{$urandom()}};
                            rresp[g] = 2'($urandom_range(0, 3));
                        end
                        if (b == r_beats[g] - 1 && inval_on_last[g]) inval[g] = 1'b1;
                        @(negedge clk);
                    end
                    rvalid[g] = 1'b0;
                    rlast[g]  = 1'b0;
                    if (inval_on_last[g]) inval[g] = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic pulse_inval(input int g);
        @(negedge clk);
        inval[g] = 1'b1;
        @(negedge clk);
        inval[g] = 1'b0;
        mb_valid[g] = 1'b0;
        mem_gen[g]++;
    endtask

    // One lookup with full checking: hit/miss behaviour, AR address, entry and error.
    task automatic run_req(input int g, input logic [23:0] idx, input logic [63:0] base, input bit inval_acc);
        logic [63:0]  la;
        logic [511:0] line;
        logic [127:0] exp_e;
        bit           exp_hit, exp_err;
        int           c0, n;
        la = ref_line_addr(base, idx, eb_of[g]);
        n = 0;
        while (req_ready[g] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (req_ready[g] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL req_ready_wait inst%0d: got %b, expected 1", g, req_ready[g]);
        end
        if (inval_acc) begin
            mb_valid[g] = 1'b0;
            mem_gen[g]++;
        end
        exp_hit = mb_valid[g] && (mb_tag[g] == la);
        exp_err = !exp_hit && (r_err[g] != 2'b00);
        line    = exp_hit ? mb_line[g] : mem_line(g, la, mem_gen[g]);
        exp_e   = exp_err ? 128'b0 : ref_entry(line, eb_of[g], swap_of[g], idx);
        c0 = ar_count[g];
        req_valid[g] = 1'b1;
        req_idx[g]   = idx;
        base_addr[g] = base;
        inval[g]     = inval_acc;
        @(negedge clk);
        req_valid[g] = 1'b0;
        inval[g]     = 1'b0;
        if (exp_hit) begin
            vectors++;
            if (rsp_valid[g] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL hit_latency inst%0d idx%0d: rsp_valid got %b, expected 1", g, idx, rsp_valid[g]);
            end
        end else begin
            n = 0;
            while (rsp_valid[g] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            vectors++;
            if (rsp_valid[g] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rsp_timeout inst%0d idx%0d: rsp_valid got %b, expected 1", g, idx, rsp_valid[g]);
            end
        end
        vectors++;
        if (entry_of(g) !== exp_e || rsp_err[g] !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL entry inst%0d idx%0d: got %h err %b, expected %h err %b",
                     g, idx, entry_of(g), rsp_err[g], exp_e, exp_err);
        end
        vectors++;
        if ((ar_count[g] - c0) !== (exp_hit ? 0 : 1)) begin
            miscompares++;
            $display("[TB] FAIL ar_count inst%0d idx%0d: got %0d reads, expected %0d", g, idx, ar_count[g] - c0, exp_hit ? 0 : 1);
        end
        if (!exp_hit) begin
            vectors++;
            if (last_ar_addr[g] !== la || last_arlen[g] !== 8'd0) begin
                miscompares++;
                $display("[TB] FAIL araddr inst%0d idx%0d: got %h len %0d, expected %h len 0",
                         g, idx, last_ar_addr[g], last_arlen[g], la);
            end
            if (exp_err || inval_on_last[g]) begin
                mb_valid[g] = 1'b0;
            end else begin
                mb_valid[g] = 1'b1;
                mb_tag[g]   = la;
                mb_line[g]  = line;
            end
        end
        rsp_ready[g] = 1'b1;
        @(negedge clk);
        rsp_ready[g] = 1'b0;
        vectors++;
        if (rsp_valid[g] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rsp_drop inst%0d: rsp_valid got %b, expected 0", g, rsp_valid[g]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if ({req_ready[g], arvalid[g], rready[g], rsp_valid[g], rsp_err[g]} !== 5'b0 ||
                araddr[g] !== 64'b0 || arlen[g] !== 8'b0 || entry_of(g) !== 128'b0) begin
                miscompares++;
                $display("[TB] FAIL %s inst%0d: got rdy%b arv%b rr%b rv%b err%b addr %h len %0d entry %h, expected all 0",
                         tag, g, req_ready[g], arvalid[g], rready[g], rsp_valid[g], rsp_err[g],
                         araddr[g], arlen[g], entry_of(g));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_values");
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready[0] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ready_before_clock: got %b, expected 0", req_ready[0]);
        end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            vectors++;
            if (req_ready[g] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL ready_after_reset inst%0d: got %b, expected 1", g, req_ready[g]);
            end
        end
    endtask

    task automatic test_att_miss_hit();
        run_req(0, 24'd10, 64'h1000, 1'b0);
        run_req(0, 24'd13, 64'h1000, 1'b0);
    endtask

    task automatic test_list_entries();
        run_req(1, 24'd5, 64'h2000, 1'b0);
        run_req(1, 24'd6, 64'h2000, 1'b0);
        run_req(2, 24'd5, 64'h2000, 1'b0);
        run_req(2, 24'd7, 64'h2000, 1'b0);
    endtask

    task automatic test_error();
        run_req(0, 24'd4, 64'h3000, 1'b0);
        r_err[0] = 2'b10;
        run_req(0, 24'd9, 64'h3000, 1'b0);
        r_err[0] = 2'b00;
        run_req(0, 24'd4, 64'h3000, 1'b0);
        r_err[0] = 2'b10;
        run_req(0, 24'd20, 64'h3000, 1'b0);
        r_err[0] = 2'b00;
        run_req(0, 24'd20, 64'h3000, 1'b0);
    endtask

    task automatic test_inval();
        run_req(0, 24'd20, 64'h4000, 1'b0);
        pulse_inval(0);
        run_req(0, 24'd21, 64'h4000, 1'b0);
        inval_on_last[0] = 1'b1;
        run_req(0, 24'd40, 64'h4000, 1'b0);
        inval_on_last[0] = 1'b0;
        run_req(0, 24'd41, 64'h4000, 1'b0);
        run_req(0, 24'd42, 64'h4000, 1'b1);
    endtask

    task automatic test_stall();
        logic [63:0]  la;
        logic [127:0] exp_e;
        int n;
        la    = ref_line_addr(64'h5000, 24'd3, 8);
        exp_e = ref_entry(mem_line(0, la, mem_gen[0]), 8, 1'b1, 24'd3);
        ar_delay[0] = 5;
        req_valid[0] = 1'b1;
        req_idx[0]   = 24'd3;
        base_addr[0] = 64'h5000;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (arvalid[0] !== 1'b1 || araddr[0] !== la) begin
                miscompares++;
                $display("[TB] FAIL ar_hold cycle%0d: got arvalid %b addr %h, expected 1 %h", i, arvalid[0], araddr[0], la);
            end
            @(negedge clk);
        end
        ar_delay[0] = 0;
        n = 0;
        while (rsp_valid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rsp_valid[0] !== 1'b1 || entry_of(0) !== exp_e) begin
                miscompares++;
                $display("[TB] FAIL rsp_hold cycle%0d: got valid %b entry %h, expected 1 %h", i, rsp_valid[0], entry_of(0), exp_e);
            end
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        mb_valid[0] = 1'b1;
        mb_tag[0]   = la;
        mb_line[0]  = mem_line(0, la, mem_gen[0]);
    endtask

    task automatic test_reset_in_r();
        bit seen;
        int n;
        r_gap[0] = 6;
        req_valid[0] = 1'b1;
        req_idx[0]   = 24'd0;
        base_addr[0] = 64'h6000;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (rready[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (rready[0] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reach_r: rready got %b, expected 1", rready[0]);
        end
        rst = 1'b1;
        #1;
        check_all_zero("reset_in_r");
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < 3; g++) mb_valid[g] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("[TB] FAIL dropped_rsp: got rsp_valid 1 after reset, expected 0");
        end
        r_gap[0] = -1;
    endtask

    task automatic test_random();
        logic [63:0] bases [3] = '{64'h1000, 64'h8000, 64'h10000};
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 30; i++) begin
                r_err[g]         = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                r_beats[g]       = $urandom_range(1, 3);
                ar_delay[g]      = $urandom_range(0, 3);
                inval_on_last[g] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 9) == 0) pulse_inval(g);
                run_req(g, 24'($urandom_range(0, 40)), bases[$urandom_range(0, 2)],
                        $urandom_range(0, 9) == 0);
            end
            r_err[g]         = 2'b00;
            r_beats[g]       = 1;
            ar_delay[g]      = 0;
            inval_on_last[g] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            req_valid[g] = 1'b0; rsp_ready[g] = 1'b0; inval[g] = 1'b0;
            req_idx[g] = '0; base_addr[g] = '0;
            ar_delay[g] = 0; r_beats[g] = 1; r_gap[g] = -1; r_err[g] = 2'b00;
            inval_on_last[g] = 1'b0; ar_count[g] = 0; mem_gen[g] = 0;
            mb_valid[g] = 1'b0; mb_tag[g] = '0; mb_line[g] = '0;
        end
        test_reset();
        test_att_miss_hit();
        test_list_entries();
        test_error();
        test_inval();
        test_stall();
        test_random();
        test_reset_in_r();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hawk_tbl_entry_rdr.md
# hawk_tbl_entry_rdr

Parametrised table-entry reader for the HAWK translation tables (ATT and list/ToL). Takes an entry index and table base address, fetches the containing 64-byte cacheline over a single-beat AXI read, extracts the addressed entry (8-byte ATT or 16-byte list entry), applies the per-8-byte byteswap, and returns it over a valid/ready handshake. A one-line buffer serves back-to-back requests to the same cacheline without a memory access. Sits between the control unit's lookup logic and the AXI read master.

## Interface
- ENTRY_BYTES, 8, entry size in bytes; legal values 8 (AttEntry) or 16 (ListEntry)
- IDX_W, 24, entry index width
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width (one cacheline)
- LEN_W, 8, arlen width
- BYTESWAP, 1, 1 = apply per-8-byte byteswap to the returned line
- LINEBUF_EN, 1, 1 = enable the single-line buffer
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  lookup request
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_idx_i  in  IDX_W  entry index
- base_addr_i  in  ADDR_W  table base; 64-byte aligned
- inval_i  in  1  invalidate line buffer (table written elsewhere)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_entry_o  out  ENTRY_BYTES*8  extracted entry
- rsp_err_o  out  1  AXI error on the fetch
- araddr_o  out  ADDR_W; arlen_o  out  LEN_W; arvalid_o  out  1; arready_i  in  1
- rdata_i  in  DATA_W; rresp_i  in  2; rvalid_i  in  1; rlast_i  in  1; rready_o  out  1

## Operation
- Byte offset = idx*ENTRY_BYTES; line_addr = base_addr_i + (offset & ~63); slot = idx mod (64/ENTRY_BYTES); entry = line[slot*ENTRY_BYTES*8 +: ENTRY_BYTES*8], taken after the byteswap.
- Request index, base and computed line address are registered on acceptance.
- FSM states: IDLE, AR, R, RSP.
  - IDLE: req_ready_o=1. On accept: on a hit (LINEBUF_EN, buffer valid, tag == line_addr) go to RSP. Otherwise go to AR.
  - AR: arvalid_o=1, arlen_o=0. Go to R on arready_i.
  - R: rready_o=1. Capture rdata_i and rresp_i on the first rvalid_i beat. Stay until the beat with rlast_i, then go to RSP. Beats after the first are discarded.
  - RSP: rsp_valid_o=1 and outputs held stable until rsp_ready_i, then return to IDLE.
- rresp_i != 0: rsp_err_o=1, rsp_entry_o=0, and the line buffer is invalidated.
- rresp_i == 0: the buffer is filled with the swapped line and tagged with line_addr.
- inval_i clears the buffer valid bit in any state. If it coincides with a fill, invalidate wins. If it coincides with a hit-accept in IDLE, the request is treated as a miss.
- Only one request is outstanding at a time.

## Timing
- Reset values: req_ready_o=0, arvalid_o=0, rready_o=0, rsp_valid_o=0, rsp_err_o=0, araddr_o=0, arlen_o=0, rsp_entry_o=0, buffer invalid, state IDLE. req_ready_o rises on the first clock after rst_i deasserts.
- Hit: request accepted at cycle 0, rsp_valid_o at cycle 1.
- Miss: accepted at cycle 0, arvalid_o at cycle 1. If arready_i is high in cycle 1, rready_o at cycle 2. rsp_valid_o one cycle after the rlast_i beat.
- arvalid_o and araddr_o hold until arready_i.
- rsp_valid_o and data hold until rsp_ready_i.
- Reset during AR or R: state returns to IDLE immediately and the in-flight response is dropped. The AXI master side is reset in the same domain.

## Structure
- Shared package (hacd_pkg) gains:
  - a tbl_rd_reqpkt_t typedef (idx, base, valid);
  - a tbl_rd_rsppkt_t typedef (entry, err, valid);
  - an ENTRY_BYTES-generic slot-extract function.
- The existing 8-byte byteswap helper is reused unchanged.
- One natural sub-module: hawk_line_buf (tag, valid, 512-bit data, fill and invalidate ports).

## Test plan
- ENTRY_BYTES=8, base=0x1000, idx=10: araddr_o=0x1040 and arlen_o=0. rsp_entry_o = swapped line bits [191:128], rsp_err_o=0.
- Follow with idx=13, same base: no arvalid_o. rsp_valid_o exactly 1 cycle after accept, carrying swapped bits [383:320].
- ENTRY_BYTES=16, base=0x2000, idx=5: araddr_o=0x2040. rsp_entry_o = swapped bits [255:128]. With BYTESWAP=0 it is the raw bits.
- Miss with rresp_i=2'b10: rsp_err_o=1, rsp_entry_o=0. A repeat of the same idx issues a new AR.
- inval_i pulsed between two same-line requests: the second request misses and issues an AR. inval_i coincident with the rlast_i beat: the next same-line request also misses.
- arready_i held low for 5 cycles and rsp_ready_i held low for 3 cycles: araddr_o and rsp_entry_o stay stable throughout. Then assert rst_i in R state: all outputs return to reset values and no response is emitted.
